alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares one 32-bit ALU datapath between two requesters, e.g. the execute stage and the branch/address unit of the five-stage core.
- Uses round-robin arbitration and valid/ready handshakes on both inputs and on the single response port.
- Holds the response in a one-entry output register, so the result appears 1 cycle after acceptance.

Parameters:
- TAG_W, 4, width of the opaque tag carried from request to response.
- RESET_PRIO, 0, requester favoured on the first contested cycle after reset (0 or 1).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_op  in  4  ALU op code
- req0_x  in  32  operand x
- req0_y  in  32  operand y
- req0_tag  in  TAG_W  requester 0 tag
- req1_valid / req1_ready / req1_op / req1_x / req1_y / req1_tag: same widths and meaning as requester 0
- rsp_valid  out  1  response register holds a result
- rsp_ready  in  1  consumer takes the response
- rsp_result  out  32  ALU result
- rsp_zero  out  1  result equals 0
- rsp_tag  out  TAG_W  tag of the originating request
- rsp_src  out  1  index of the originating requester
- busy  out  1  equals rsp_valid

Behaviour:
- Op encoding:
  - 0 ADD; 8 SUB; 1 SLL (shift by y[4:0])
  - 2 SLT (signed compare); 3 SLTU (unsigned compare); 4 XOR
  - 5 SRL (logical); 9 SRA (arithmetic, sign-filled); 6 OR; 7 AND
  - any other code gives result 0, zero 1.
  - ADD/SUB wrap modulo 2^32, with no carry or overflow output.
- Output register states: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
- can_accept = EMPTY or (FULL and rsp_ready). A FULL register drained and refilled in the same cycle sustains 1 op/cycle.
- Grant (combinational):
  - Only one valid: that requester is granted.
  - Both valid: grant the requester that is not last_grant.
  - reqN_ready = grantN and can_accept. reqN_ready never depends on reqN_valid of the same requester beyond the grant selection.
- Transfer on reqN_valid and reqN_ready:
  - Result, zero, tag and src are registered at the next edge; state goes to FULL.
  - last_grant is set to N.
- Drain on rsp_valid and rsp_ready with no new transfer: state goes to EMPTY. rsp_* data is held stable while FULL and not ready.
- last_grant changes only on a transfer. Its reset value is 1 - RESET_PRIO.
- Reset (async assert, sync deassert expected upstream):
  - rsp_valid=0; rsp_result=0; rsp_zero=0; rsp_tag=0; rsp_src=0; busy=0.
  - Reset mid-transfer discards the pending response.
- Requesters may change op/operands while not ready. The values registered are those present in the accept cycle.
- No combinational path from rsp_ready to rsp_* data. A path from rsp_ready to reqN_ready is permitted.

Optional Feature:
- Macro: ALU_ARB_STATS_EN.
- When defined, adds output ports:
  - grant_cnt0 [31:0] and grant_cnt1 [31:0]: transfers per requester.
  - stall_cnt [31:0]: cycles with any reqN_valid and no transfer.
- Counters saturate at 0xFFFFFFFF and reset to 0.
- When undefined, these ports and registers do not exist and the behaviour is otherwise identical.

Test Plan:
- Reset, then req0 ADD x=5 y=7 tag=3, rsp_ready=1 -> next cycle rsp_valid=1, rsp_result=12, rsp_zero=0, rsp_tag=3, rsp_src=0; then rsp_valid=0.
- Both valid for 4 cycles with rsp_ready=1 and RESET_PRIO=0 -> grants 0,1,0,1, giving one response per cycle with rsp_src alternating.
- rsp_ready=0 while FULL with a result from req1 SUB x=3 y=3 -> rsp_result=0, rsp_zero=1 held 3 cycles; req0_ready=0 throughout. Raising rsp_ready accepts the pending req0 in that cycle.
- Op cases:
  - SRA x=0x80000000 y=4 -> 0xF8000000; SRL with the same operands -> 0x08000000.
  - SLT x=0xFFFFFFFF y=1 -> 1; SLTU with the same operands -> 0.
  - op=15 -> result 0, zero 1.
- Assert rst_n low while FULL -> rsp_valid falls immediately, with no edge needed. After release, the first new request returns a correct result and last_grant is back at its reset value.
- With ALU_ARB_STATS_EN: 5 req0 transfers, 2 req1 transfers and 3 backpressure cycles -> grant_cnt0=5, grant_cnt1=2, stall_cnt=3.

Source files
------------

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle for alu_share_arbiter: two requester channels and one response channel.
// slave is the arbiter's view, master is the requesters'/consumer's view.
interface alu_share_arbiter_if #(
    parameter int TAG_W = 4
);
    logic             req0_valid;
    logic             req0_ready;
    logic [3:0]       req0_op;
    logic [31:0]      req0_x;
    logic [31:0]      req0_y;
    logic [TAG_W-1:0] req0_tag;

    logic             req1_valid;
    logic             req1_ready;
    logic [3:0]       req1_op;
    logic [31:0]      req1_x;
    logic [31:0]      req1_y;
    logic [TAG_W-1:0] req1_tag;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_result;
    logic             rsp_zero;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_src;
    logic             busy;

    modport slave (
        input  req0_valid, req0_op, req0_x, req0_y, req0_tag,
        output req0_ready,
        input  req1_valid, req1_op, req1_x, req1_y, req1_tag,
        output req1_ready,
        output rsp_valid, rsp_result, rsp_zero, rsp_tag, rsp_src, busy,
        input  rsp_ready
    );

    modport master (
        output req0_valid, req0_op, req0_x, req0_y, req0_tag,
        input  req0_ready,
        output req1_valid, req1_op, req1_x, req1_y, req1_tag,
        input  req1_ready,
        input  rsp_valid, rsp_result, rsp_zero, rsp_tag, rsp_src, busy,
        output rsp_ready
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one 32-bit ALU between two requesters, result held in a one-entry output register.
// Define ALU_ARB_STATS_EN to add saturating grant/stall counters as extra output ports.
module alu_share_arbiter #(
    parameter int TAG_W      = 4,
    parameter bit RESET_PRIO = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_share_arbiter_if.slave  bus
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [31:0]         grant_cnt0,
    output logic [31:0]         grant_cnt1,
    output logic [31:0]         stall_cnt
`endif
);
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]       state;
    logic             last_grant;
    logic             sel;
    logic             can_accept;
    logic             xfer0;
    logic             xfer1;
    logic             xfer;
    logic [3:0]       op_sel;
    logic [31:0]      x_sel;
    logic [31:0]      y_sel;
    logic [TAG_W-1:0] tag_sel;
    logic [31:0]      alu_res;

    function automatic logic [31:0] alu_eval(input logic [3:0] op,
                                             input logic [31:0] x,
                                             input logic [31:0] y);
        logic [31:0] r;
        case (op)
            4'd0:    r = x + y;
            4'd8:    r = x - y;
            4'd1:    r = x << y[4:0];
            4'd2:    r = {31'd0, $signed(x) < $signed(y)};
            4'd3:    r = {31'd0, x < y};
            4'd4:    r = x ^ y;
            4'd5:    r = x >> y[4:0];
            4'd9:    r = $unsigned($signed(x) >>> y[4:0]);
            4'd6:    r = x | y;
            4'd7:    r = x & y;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // Contested cycles go to whoever was not served last; otherwise the sole requester wins.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        sel = 1'b0;
        if (bus.req0_valid && bus.req1_valid)
            sel = ~last_grant;
        else if (bus.req1_valid)
            sel = 1'b1;
    end

    assign can_accept     = (state == ST_EMPTY) || bus.rsp_ready;
    assign bus.req0_ready = can_accept && !sel;
    assign bus.req1_ready = can_accept && sel;
    assign xfer0          = bus.req0_valid && bus.req0_ready;
    assign xfer1          = bus.req1_valid && bus.req1_ready;
    assign xfer           = xfer0 || xfer1;

    always_comb begin
        op_sel  = sel ? bus.req1_op  : bus.req0_op;
        x_sel   = sel ? bus.req1_x   : bus.req0_x;
        y_sel   = sel ? bus.req1_y   : bus.req0_y;
        tag_sel = sel ? bus.req1_tag : bus.req0_tag;
        alu_res = alu_eval(op_sel, x_sel, y_sel);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_EMPTY;
            last_grant     <= ~RESET_PRIO;
            // NOTE: the data registers are reset too because their zero reset value is visible on rsp_*.
            bus.rsp_result <= 32'd0;
            bus.rsp_zero   <= 1'b0;
            bus.rsp_tag    <= '0;
            bus.rsp_src    <= 1'b0;
        end else if (xfer) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state          <= ST_FULL;
            last_grant     <= sel;
            bus.rsp_result <= alu_res;
            bus.rsp_zero   <= (alu_res == 32'd0);
            bus.rsp_tag    <= tag_sel;
            bus.rsp_src    <= sel;
        end else if (state == ST_FULL && bus.rsp_ready) begin
            state <= ST_EMPTY;
        end
    end

    assign bus.rsp_valid = (state == ST_FULL);
    assign bus.busy      = (state == ST_FULL);

`ifdef ALU_ARB_STATS_EN
    logic stall;
    assign stall = (bus.req0_valid || bus.req1_valid) && !xfer;

    // Counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt0 <= 32'd0;
            grant_cnt1 <= 32'd0;
            stall_cnt  <= 32'd0;
        end else begin
            if (xfer0 && grant_cnt0 != 32'hFFFF_FFFF) grant_cnt0 <= grant_cnt0 + 32'd1;
            if (xfer1 && grant_cnt1 != 32'hFFFF_FFFF) grant_cnt1 <= grant_cnt1 + 32'd1;
            if (stall && stall_cnt  != 32'hFFFF_FFFF) stall_cnt  <= stall_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: scoreboard queue fed by a behavioural model, drained by a monitor.
// Build with ALU_ARB_STATS_EN defined to also check the statistics counters.
module tb_alu_share_arbiter;
    localparam int TAG_W = 4;

    typedef struct {
        logic [31:0]      res;
        logic             zero;
        logic [TAG_W-1:0] tag;
        logic             src;
    } rsp_t;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    rsp_t sb[$];
    logic m_full;
    int   m_last;
    int   m_cnt0, m_cnt1, m_stall;

    alu_share_arbiter_if #(.TAG_W(TAG_W)) bus ();

`ifdef ALU_ARB_STATS_EN
    logic [31:0] grant_cnt0, grant_cnt1, stall_cnt;
`endif

    alu_share_arbiter #(.TAG_W(TAG_W), .RESET_PRIO(1'b0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
`ifdef ALU_ARB_STATS_EN
        ,
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1),
        .stall_cnt  (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference ALU from plain integer arithmetic (shifts as multiply/divide by powers of two).
    function automatic logic [31:0] ref_alu(input int op, input logic [31:0] x, input logic [31:0] y);
        longint ux = longint'(x);
        longint uy = longint'(y);
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        longint p  = 1;
        longint r;
        for (int i = 0; i < int'(y[4:0]); i++) p = p * 2;
        case (op)
            0:       r = ux + uy;
            8:       r = ux - uy;
            1:       r = ux * p;
            2:       r = (sx < sy) ? 1 : 0;
            3:       r = (ux < uy) ? 1 : 0;
            4:       r = ux ^ uy;
            5:       r = ux / p;
            9:       r = (sx - (((sx % p) + p) % p)) / p;
            6:       r = ux | uy;
            7:       r = ux & uy;
            default: r = 0;
        endcase
        return r[31:0];
    endfunction

    task automatic model_reset();
        sb.delete();
        m_full  = 1'b0;
        m_last  = 1;
        m_cnt0  = 0;
        m_cnt1  = 0;
        m_stall = 0;
    endtask

    task automatic drive_idle();
        bus.req0_valid = 0; bus.req0_op = 0; bus.req0_x = 0; bus.req0_y = 0; bus.req0_tag = 0;
        bus.req1_valid = 0; bus.req1_op = 0; bus.req1_x = 0; bus.req1_y = 0; bus.req1_tag = 0;
        bus.rsp_ready  = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive_idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // One clock cycle: drive inputs, compare handshake against the model, push expected responses.
    task automatic step(input logic v0, input logic [3:0] op0, input logic [31:0] x0, input logic [31:0] y0,
                        input logic [TAG_W-1:0] t0,
                        input logic v1, input logic [3:0] op1, input logic [31:0] x1, input logic [31:0] y1,
                        input logic [TAG_W-1:0] t1, input logic rr);
        logic can, acc;
        int   win;
        rsp_t e;
        @(posedge clk);
        #1;
        bus.req0_valid = v0; bus.req0_op = op0; bus.req0_x = x0; bus.req0_y = y0; bus.req0_tag = t0;
        bus.req1_valid = v1; bus.req1_op = op1; bus.req1_x = x1; bus.req1_y = y1; bus.req1_tag = t1;
        bus.rsp_ready  = rr;
        #2;
        check("rsp_valid", bus.rsp_valid, m_full);
        check("busy", bus.busy, m_full);
        can = !m_full || rr;
        if (v0 && v1) win = 1 - m_last;
        else if (v1)  win = 1;
        else          win = 0;
        if (v0) check("req0_ready", bus.req0_ready, can && win == 0);
        if (v1) check("req1_ready", bus.req1_ready, can && win == 1);
        acc = can && (v0 || v1);
        if (acc) begin
            e.res  = (win == 0) ? ref_alu(int'(op0), x0, y0) : ref_alu(int'(op1), x1, y1);
            e.zero = (e.res == 32'd0);
            e.tag  = (win == 0) ? t0 : t1;
            e.src  = (win == 1);
            sb.push_back(e);
            m_last = win;
            if (win == 0) m_cnt0++; else m_cnt1++;
            m_full = 1'b1;
        end else begin
            if (v0 || v1) m_stall++;
            if (m_full && rr) m_full = 1'b0;
        end
    endtask

    task automatic issue0(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                          input logic [TAG_W-1:0] t, input logic rr);
        step(1, op, x, y, t, 0, 0, 0, 0, 0, rr);
    endtask

    task automatic issue1(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                          input logic [TAG_W-1:0] t, input logic rr);
        step(0, 0, 0, 0, 0, 1, op, x, y, t, rr);
    endtask

    task automatic idle(input logic rr);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, rr);
    endtask

    // Monitor: compares the held response every cycle it is valid, pops on the handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && bus.rsp_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: got result 0x%0h with empty scoreboard at %0t",
                             bus.rsp_result, $time);
                end else begin
                    check("rsp", {bus.rsp_result, bus.rsp_zero, bus.rsp_tag, bus.rsp_src},
                          {sb[0].res, sb[0].zero, sb[0].tag, sb[0].src});
                    if (bus.rsp_ready) void'(sb.pop_front());
                end
            end
        end
    end

    logic [3:0]  tv_op  [5] = '{4'd9, 4'd5, 4'd2, 4'd3, 4'd15};
    logic [31:0] tv_x   [5] = '{32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234};
    logic [31:0] tv_y   [5] = '{32'd4, 32'd4, 32'd1, 32'd1, 32'd5};
    logic [31:0] tv_exp [5] = '{32'hF800_0000, 32'h0800_0000, 32'd1, 32'd0, 32'd0};

    initial begin
        rst_n = 1'b0;
        drive_idle();
        model_reset();
        #3;
        check("reset_rsp_valid", bus.rsp_valid, 0);
        check("reset_busy", bus.busy, 0);
        check("reset_result", bus.rsp_result, 0);
        check("reset_zero", bus.rsp_zero, 0);
        check("reset_tag", bus.rsp_tag, 0);
        check("reset_src", bus.rsp_src, 0);
        do_reset();

        // Single ADD, result one cycle after acceptance, then drained.
        issue0(4'd0, 32'd5, 32'd7, 4'd3, 1);
        idle(1);
        check("add_valid", bus.rsp_valid, 1);
        check("add_result", bus.rsp_result, 12);
        check("add_zero", bus.rsp_zero, 0);
        check("add_tag", bus.rsp_tag, 3);
        check("add_src", bus.rsp_src, 0);
        idle(1);
        check("add_drained", bus.rsp_valid, 0);

        // Contested requests alternate starting at requester 0.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1, 4'd0, 32'(i), 32'd1, 4'(i), 1, 4'd8, 32'd10, 32'(i), 4'(i + 8), 1);
            check("grant_alt", bus.req0_ready, (i % 2) == 0);
        end
        idle(1);
        idle(1);

        // Backpressure holds a zero result from req1 while req0 waits.
        issue1(4'd8, 32'd3, 32'd3, 4'd5, 1);
        for (int i = 0; i < 3; i++) begin
            issue0(4'd6, 32'hF0, 32'h0F, 4'd6, 0);
            check("bp_req0_ready", bus.req0_ready, 0);
            check("bp_result", bus.rsp_result, 0);
            check("bp_zero", bus.rsp_zero, 1);
        end
        issue0(4'd6, 32'hF0, 32'h0F, 4'd6, 1);
        check("bp_release_ready", bus.req0_ready, 1);
        idle(1);
        idle(1);

        // Directed op corner cases.
        for (int i = 0; i < 5; i++) begin
            issue0(tv_op[i], tv_x[i], tv_y[i], 4'(i), 1);
            idle(1);
            check("op_result", bus.rsp_result, tv_exp[i]);
            check("op_zero", bus.rsp_zero, tv_exp[i] == 32'd0);
        end
        idle(1);

        // Asynchronous reset while FULL.
        issue1(4'd0, 32'd1, 32'd2, 4'd9, 0);
        idle(0);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", bus.rsp_valid, 0);
        check("async_rst_result", bus.rsp_result, 0);
        drive_idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step(1, 4'd4, 32'hFF00, 32'h0FF0, 4'd1, 1, 4'd7, 32'hFF, 32'hF, 4'd2, 1);
        check("post_rst_grant", bus.req0_ready, 1);
        idle(1);
        check("post_rst_result", bus.rsp_result, 32'hF0F0);
        idle(1);

`ifdef ALU_ARB_STATS_EN
        do_reset();
        for (int i = 0; i < 5; i++) issue0(4'd0, 32'(i), 32'd1, 4'd0, 1);
        for (int i = 0; i < 2; i++) issue1(4'd0, 32'(i), 32'd2, 4'd1, 1);
        for (int i = 0; i < 3; i++) issue0(4'd0, 32'd1, 32'd1, 4'd0, 0);
        idle(1);
        check("stats_grant0", grant_cnt0, 5);
        check("stats_grant1", grant_cnt1, 2);
        check("stats_stall", stall_cnt, 3);
        idle(1);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] x0, y0, x1, y1;
            y0 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            x0 = ($urandom_range(0, 4) == 0) ? y0 : $urandom;
            y1 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            x1 = ($urandom_range(0, 4) == 0) ? y1 : $urandom;
            step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), x0, y0, 4'($urandom),
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), x1, y1, 4'($urandom),
                 1'($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 3; i++) idle(1);
        check("sb_drained", sb.size(), 0);
`ifdef ALU_ARB_STATS_EN
        check("rand_grant0", grant_cnt0, m_cnt0);
        check("rand_grant1", grant_cnt1, m_cnt1);
        check("rand_stall", stall_cnt, m_stall);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
